// File: rtl/fpu_sp_req_ctrl_pkg.sv
// Shared definitions for the single-precision FPU request sequencer.
// Opcodes, FSM states, the legal-cmd check and the timeout NaN live here.
package fpu_sp_req_ctrl_pkg;

    localparam logic [3:0] CMD_FPU_SP_ADD  = 4'h0;
    localparam logic [3:0] CMD_FPU_SP_SUB  = 4'h1;
    localparam logic [3:0] CMD_FPU_SP_MUL  = 4'h2;
    localparam logic [3:0] CMD_FPU_SP_DIV  = 4'h3;
    localparam logic [3:0] CMD_FPU_SP_SQRT = 4'h4;
    localparam logic [3:0] CMD_FPU_SP_CMP  = 4'h5;
    localparam logic [3:0] CMD_FPU_SP_F2I  = 4'h6;
    localparam logic [3:0] CMD_FPU_SP_I2F  = 4'h7;

    localparam logic [31:0] FPU_SP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fpu_sp_state_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] din1;
        logic [31:0] din2;
    } fpu_op_t;

    // Opcodes above I2F have no FPU unit behind them.
    function automatic logic cmd_is_legal(input logic [3:0] cmd);
        return (cmd <= CMD_FPU_SP_I2F);
    endfunction

endpackage

// File: rtl/fpu_sp_req_ctrl_if.sv
// Request, response and FPU-side signals of the sequencer.
// slave = the sequencer itself, master = its environment.
interface fpu_sp_req_ctrl_if #(
    parameter int unsigned TAG_W = 4
);

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cmd;
    logic [31:0]      req_din1;
    logic [31:0]      req_din2;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    logic [3:0]       fpu_cmd;
    logic [31:0]      fpu_din1;
    logic [31:0]      fpu_din2;
    logic             fpu_dval;
    logic [31:0]      fpu_result;
    logic             fpu_rdy;

    modport slave (
        input  req_valid, req_cmd, req_din1, req_din2, req_tag,
        input  resp_ready, fpu_result, fpu_rdy,
        output req_ready, resp_valid, resp_result, resp_tag, resp_err,
        output fpu_cmd, fpu_din1, fpu_din2, fpu_dval
    );

    modport master (
        output req_valid, req_cmd, req_din1, req_din2, req_tag,
        output resp_ready, fpu_result, fpu_rdy,
        input  req_ready, resp_valid, resp_result, resp_tag, resp_err,
        input  fpu_cmd, fpu_din1, fpu_din2, fpu_dval
    );

endinterface

// File: rtl/fpu_req_fifo.sv
// Synchronous request FIFO holding {cmd, din1, din2, tag}.
// Head entry is presented combinationally on op_o/tag_o.
module fpu_req_fifo
    import fpu_sp_req_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  fpu_op_t                      op_i,
    input  logic [TAG_W-1:0]             tag_i,
    input  logic                         pop_i,
    output fpu_op_t                      op_o,
    output logic [TAG_W-1:0]             tag_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef struct packed {
        fpu_op_t          op;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Guard here too so a misbehaving caller cannot corrupt the count.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign op_o  = mem_q[rd_ptr_q].op;
    assign tag_o = mem_q[rd_ptr_q].tag;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= '{op: op_i, tag: tag_i};
    end

endmodule

// File: rtl/fpu_sp_req_ctrl.sv
// Sequencer in front of the single-precision FPU: queues requests, issues one op
// at a time, returns result+tag. Define FPU_SP_TIMEOUT_EN to bound the WAIT state.
module fpu_sp_req_ctrl
    import fpu_sp_req_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_sp_req_ctrl_if.slave     bus
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fpu_sp_req_ctrl: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_tmo
        $error("fpu_sp_req_ctrl: TIMEOUT_CYC must be >= 1");
    end

    fpu_sp_state_e     state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [31:0]       din1_q, din1_d;
    logic [31:0]       din2_q, din2_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       res_q, res_d;
    logic [TAG_W-1:0]  rtag_q, rtag_d;
    logic              err_q, err_d;

    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    fpu_op_t           head_op, req_op;
    logic [TAG_W-1:0]  head_tag;

`ifdef FPU_SP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]     tmo_q, tmo_d;
`endif

    // req_ready depends only on the registered count, never on req_valid.
    assign bus.req_ready = (fifo_cnt < CW'(DEPTH));
    assign fifo_push     = bus.req_valid & ~fifo_full;
    assign req_op        = '{cmd: bus.req_cmd, din1: bus.req_din1, din2: bus.req_din2};

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .op_i    (req_op),
        .tag_i   (bus.req_tag),
        .pop_i   (fifo_pop),
        .op_o    (head_op),
        .tag_o   (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        din1_d   = din1_q;
        din2_d   = din2_q;
        tag_d    = tag_q;
        res_d    = res_q;
        rtag_d   = rtag_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
`ifdef FPU_SP_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (cmd_is_legal(head_op.cmd)) begin
                        cmd_d   = head_op.cmd;
                        din1_d  = head_op.din1;
                        din2_d  = head_op.din2;
                        tag_d   = head_tag;
                        state_d = ISSUE;
                    end else begin
                        // Illegal op completes locally; the FPU never sees it.
                        res_d   = '0;
                        err_d   = 1'b1;
                        rtag_d  = head_tag;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
`ifdef FPU_SP_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.fpu_rdy) begin
                    res_d   = bus.fpu_result;
                    err_d   = 1'b0;
                    rtag_d  = tag_q;
                    state_d = RESP;
                end
`ifdef FPU_SP_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    res_d   = FPU_SP_QNAN;
                    err_d   = 1'b1;
                    rtag_d  = tag_q;
                    state_d = RESP;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            din1_q  <= '0;
            din2_q  <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            rtag_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            din1_q  <= din1_d;
            din2_q  <= din2_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            rtag_q  <= rtag_d;
            err_q   <= err_d;
        end
    end

`ifdef FPU_SP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    // cmd/operands are held outside ISSUE/WAIT so the FPU's cmd-muxed rdy stays deterministic.
    assign bus.fpu_cmd     = cmd_q;
    assign bus.fpu_din1    = din1_q;
    assign bus.fpu_din2    = din2_q;
    assign bus.fpu_dval    = (state_q == ISSUE);
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_result = res_q;
    assign bus.resp_tag    = rtag_q;
    assign bus.resp_err    = err_q;

endmodule

// File: tb/tb_fpu_sp_req_ctrl.sv
// Directed bench for fpu_sp_req_ctrl; the bench plays the FPU by hand.
// Timeout steps run only when FPU_SP_TIMEOUT_EN is defined (TIMEOUT_CYC=8).
module tb_fpu_sp_req_ctrl;
    import fpu_sp_req_ctrl_pkg::*;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_sp_req_ctrl_if #(.TAG_W(TAG_W)) bus ();

    fpu_sp_req_ctrl #(
        .DEPTH       (2),
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int dval_cnt = 0;
    int cmd_chg = 0;
    logic in_wait = 1'b0;
    logic [3:0] wcmd = '0;

    // Count dval pulses; flag any fpu_cmd change between dval and rdy.
    always @(posedge clk) begin
        if (bus.fpu_dval) dval_cnt <= dval_cnt + 1;
        if (!rst_n) begin
            in_wait <= 1'b0;
        end else if (bus.fpu_dval) begin
            in_wait <= 1'b1;
            wcmd    <= bus.fpu_cmd;
        end else if (in_wait) begin
            if (bus.fpu_cmd !== wcmd) cmd_chg <= cmd_chg + 1;
            if (bus.fpu_rdy) in_wait <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_din1  = a;
        bus.req_din2  = b;
        bus.req_tag   = tag;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.req_ready) chk("push_ready", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_dval(input int n);
        int k;
        k = 0;
        while (dval_cnt < n && k < 100) begin
            step();
            k++;
        end
        if (dval_cnt < n) chk("dval_seen", dval_cnt, n);
    endtask

    task automatic fpu_complete(input int n, input logic [3:0] cmd, input logic [31:0] res,
                                input int dly);
        wait_dval(n);
        chk("fpu_cmd", bus.fpu_cmd, cmd);
        repeat (dly) step();
        bus.fpu_result = res;
        bus.fpu_rdy    = 1'b1;
        step();
        bus.fpu_rdy    = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [31:0] res, input logic [3:0] rtag,
                              input logic err);
        int k;
        k = 0;
        while (!bus.resp_valid && k < 100) begin
            step();
            k++;
        end
        chk({tag, "_valid"}, bus.resp_valid, 1'b1);
        chk({tag, "_result"}, bus.resp_result, res);
        chk({tag, "_tag"}, bus.resp_tag, rtag);
        chk({tag, "_err"}, bus.resp_err, err);
        if (bus.resp_ready) step();
    endtask

    initial begin
        int base;
        int seen;
        bus.req_valid  = 1'b0;
        bus.req_cmd    = '0;
        bus.req_din1   = '0;
        bus.req_din2   = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
        bus.fpu_result = '0;
        bus.fpu_rdy    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_dval", bus.fpu_dval, 1'b0);
        chk("rst_fpu_cmd", bus.fpu_cmd, 4'h0);
        chk("rst_din1", bus.fpu_din1, 32'h0);
        chk("rst_result", bus.resp_result, 32'h0);
        chk("rst_err", bus.resp_err, 1'b0);
        rst_n = 1'b1;
        step();

        // Single ADD 1.0 + 2.0
        base = dval_cnt;
        push(CMD_FPU_SP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd3);
        wait_dval(base + 1);
        chk("add_dval_low", bus.fpu_dval, 1'b0);
        chk("add_din1", bus.fpu_din1, 32'h3F80_0000);
        chk("add_din2", bus.fpu_din2, 32'h4000_0000);
        fpu_complete(base + 1, CMD_FPU_SP_ADD, 32'h4040_0000, 2);
        check_resp("add", 32'h4040_0000, 4'd3, 1'b0);
        chk("add_one_dval", dval_cnt - base, 1);

        // Three back-to-back requests; FIFO fills behind the first op
        base = dval_cnt;
        push(CMD_FPU_SP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd1);
        push(CMD_FPU_SP_DIV, 32'h3F80_0000, 32'h4080_0000, 4'd2);
        push(CMD_FPU_SP_I2F, 32'h0000_0005, 32'h0000_0000, 4'd4);
        chk("b2b_full_ready", bus.req_ready, 1'b0);
        fpu_complete(base + 1, CMD_FPU_SP_MUL, 32'h40C0_0000, 3);
        check_resp("b2b_mul", 32'h40C0_0000, 4'd1, 1'b0);
        fpu_complete(base + 2, CMD_FPU_SP_DIV, 32'h3E80_0000, 4);
        check_resp("b2b_div", 32'h3E80_0000, 4'd2, 1'b0);
        fpu_complete(base + 3, CMD_FPU_SP_I2F, 32'h40A0_0000, 1);
        check_resp("b2b_i2f", 32'h40A0_0000, 4'd4, 1'b0);
        chk("b2b_cmd_stable", cmd_chg, 0);

        // Response backpressure for 10 cycles while the FIFO fills
        bus.resp_ready = 1'b0;
        base = dval_cnt;
        push(CMD_FPU_SP_SUB, 32'h4040_0000, 32'h3F80_0000, 4'd1);
        fpu_complete(base + 1, CMD_FPU_SP_SUB, 32'h4000_0000, 1);
        check_resp("bp", 32'h4000_0000, 4'd1, 1'b0);
        push(CMD_FPU_SP_ADD, 32'h4000_0000, 32'h4000_0000, 4'hA);
        push(CMD_FPU_SP_MUL, 32'h4040_0000, 32'h4040_0000, 4'hB);
        chk("bp_fifo_full", bus.req_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid_hold", bus.resp_valid, 1'b1);
            chk("bp_result_hold", bus.resp_result, 32'h4000_0000);
            chk("bp_tag_hold", bus.resp_tag, 4'd1);
            chk("bp_no_dval", dval_cnt, base + 1);
        end
        bus.resp_ready = 1'b1;
        step();
        fpu_complete(base + 2, CMD_FPU_SP_ADD, 32'h4080_0000, 0);
        check_resp("bp_add", 32'h4080_0000, 4'hA, 1'b0);
        fpu_complete(base + 3, CMD_FPU_SP_MUL, 32'h4110_0000, 2);
        check_resp("bp_mul", 32'h4110_0000, 4'hB, 1'b0);

        // Illegal command never reaches the FPU
        base = dval_cnt;
        push(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7);
        check_resp("ill", 32'h0, 4'd7, 1'b1);
        step();
        step();
        chk("ill_no_dval", dval_cnt, base);

        // Reset during WAIT, then a stray fpu_rdy
        base = dval_cnt;
        push(CMD_FPU_SP_ADD, 32'h3F80_0000, 32'h3F80_0000, 4'd5);
        wait_dval(base + 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("wrst_resp_valid", bus.resp_valid, 1'b0);
        chk("wrst_fpu_cmd", bus.fpu_cmd, 4'h0);
        chk("wrst_din1", bus.fpu_din1, 32'h0);
        chk("wrst_din2", bus.fpu_din2, 32'h0);
        chk("wrst_result", bus.resp_result, 32'h0);
        chk("wrst_tag", bus.resp_tag, 4'h0);
        chk("wrst_req_ready", bus.req_ready, 1'b1);
        step();
        rst_n = 1'b1;
        bus.fpu_result = 32'hDEAD_BEEF;
        bus.fpu_rdy    = 1'b1;
        step();
        bus.fpu_rdy    = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid) seen++;
            step();
        end
        chk("wrst_no_resp", seen, 0);
        chk("wrst_no_dval", dval_cnt, base + 1);
        push(CMD_FPU_SP_MUL, 32'h4000_0000, 32'h4080_0000, 4'd9);
        fpu_complete(base + 2, CMD_FPU_SP_MUL, 32'h4100_0000, 1);
        check_resp("post_rst", 32'h4100_0000, 4'd9, 1'b0);

`ifdef FPU_SP_TIMEOUT_EN
        // Timeout after exactly 8 WAIT cycles
        base = dval_cnt;
        push(CMD_FPU_SP_ADD, 32'h3F80_0000, 32'h3F80_0000, 4'd2);
        wait_dval(base + 1);
        repeat (7) step();
        chk("tmo_not_yet", bus.resp_valid, 1'b0);
        step();
        chk("tmo_valid", bus.resp_valid, 1'b1);
        chk("tmo_result", bus.resp_result, FPU_SP_QNAN);
        chk("tmo_err", bus.resp_err, 1'b1);
        chk("tmo_tag", bus.resp_tag, 4'd2);
        step();
        // rdy on the expiry cycle wins
        push(CMD_FPU_SP_SUB, 32'h4000_0000, 32'h3F80_0000, 4'd3);
        wait_dval(base + 2);
        repeat (7) step();
        bus.fpu_result = 32'h3F80_0000;
        bus.fpu_rdy    = 1'b1;
        step();
        bus.fpu_rdy    = 1'b0;
        chk("tmo_race_valid", bus.resp_valid, 1'b1);
        chk("tmo_race_result", bus.resp_result, 32'h3F80_0000);
        chk("tmo_race_err", bus.resp_err, 1'b0);
        step();
`endif

        chk("cmd_stable_wait", cmd_chg, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_sp_req_ctrl.md
Name: fpu_sp_req_ctrl

Overview:
- Request sequencer that sits directly upstream of the single-precision FPU top.
- Accepts operation requests on a valid/ready interface and buffers them in a small FIFO.
- Issues one operation at a time to the FPU: one-cycle dval, with cmd/din1/din2 held stable until the selected unit's rdy.
- Returns result plus tag on a valid/ready response interface.

Parameters:
- DEPTH, 2, request FIFO entries; power of two, ≥2.
- TAG_W, 4, width of the opaque request tag carried through to the response.
- TIMEOUT_CYC, 64, WAIT-state cycle limit; used only with FPU_SP_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_cmd  in  4  operation code (CMD_FPU_SP_*)
- req_din1  in  32  operand 1
- req_din2  in  32  operand 2
- req_tag  in  TAG_W  request tag
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_result  out  32  result word
- resp_tag  out  TAG_W  tag of the completed request
- resp_err  out  1  illegal cmd or timeout
- fpu_cmd  out  4  cmd to FPU; stable from ISSUE through WAIT
- fpu_din1  out  32  operand 1 to FPU
- fpu_din2  out  32  operand 2 to FPU
- fpu_dval  out  1  one-cycle start strobe
- fpu_result  in  32  FPU result
- fpu_rdy  in  1  FPU completion

Behaviour:
- Reset: async, active-low. FIFO pointers/count cleared. State=IDLE.
  - resp_valid=0, fpu_dval=0.
  - fpu_cmd, fpu_din1, fpu_din2, resp_result, resp_tag, resp_err all 0.
  - Reset mid-operation abandons the in-flight op and all queued requests; a later fpu_rdy in IDLE is ignored.
- Request FIFO:
  - Push on req_valid&req_ready. req_ready = count<DEPTH, registered-count based, no combinational path from req_valid.
  - Pop in IDLE when non-empty. Simultaneous push and pop when full is not allowed (req_ready=0); when empty, the pushed entry is popped the next cycle at the earliest.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if FIFO non-empty, pop head. A legal cmd loads fpu_cmd/din1/din2 and a tag register, then goes to ISSUE. An illegal cmd loads resp_result=0, resp_err=1, resp_tag, goes to RESP, and no dval is issued.
  - ISSUE: fpu_dval=1 for exactly this cycle, then WAIT.
  - WAIT: fpu_dval=0, operands held. When fpu_rdy=1, capture resp_result=fpu_result, resp_err=0, then RESP. fpu_rdy is ignored outside WAIT.
    - Sub-unit contract: rdy is low from the cycle after dval until completion.
  - RESP: resp_valid=1, outputs stable while resp_ready=0. On resp_valid&resp_ready, go to IDLE. Back-to-back ops therefore have minimum 1 bubble cycle.
- Latency: FIFO push to dval ≥2 cycles; fpu_rdy to resp_valid is 1 cycle.
- Single outstanding op. Responses are in request order.
- fpu_cmd holds its last value in IDLE/RESP. This keeps the FPU's cmd-muxed rdy/result deterministic.

Optional Feature:
- Macro: FPU_SP_TIMEOUT_EN.
- Defined: a counter clears on entering WAIT and increments each WAIT cycle. At TIMEOUT_CYC cycles without fpu_rdy, go to RESP with resp_result=32'h7FC00000 (canonical qNaN) and resp_err=1.
  - fpu_rdy in the same cycle as expiry wins: normal result, err=0.
- Undefined: no counter; WAIT is held indefinitely.

Decomposition:
- Shared package holds: the CMD_FPU_SP_* codes, the legal-cmd check function, the state enum {IDLE, ISSUE, WAIT, RESP}, and the canonical-NaN constant.
- One sub-module, fpu_req_fifo: a parameterized sync FIFO holding {cmd, din1, din2, tag} with push/pop/full/empty/count.

Test Plan:
- Single ADD, 32'h3F800000 + 32'h40000000, tag 3 → exactly one fpu_dval pulse; resp_result=32'h40400000, resp_tag=3, resp_err=0.
- Three back-to-back requests (MUL 2.0×3.0, DIV 1.0/4.0, I2F 5), DEPTH=2, req_valid held → req_ready drops when full. Responses arrive in order: 32'h40C00000, 32'h3E800000, 32'h40A00000. fpu_cmd never changes while in WAIT.
- Backpressure: resp_ready=0 for 10 cycles → resp_* stable, no new dval issued, FIFO still accepts up to DEPTH entries.
- Illegal cmd 4'hF, tag 7 → no fpu_dval; resp_err=1, resp_result=0, resp_tag=7.
- rst_n asserted during WAIT → outputs go to reset values immediately. A late fpu_rdy produces no response. The next request completes normally.
- With FPU_SP_TIMEOUT_EN, TIMEOUT_CYC=8, fpu_rdy tied low → response after 8 WAIT cycles with resp_result=32'h7FC00000, resp_err=1.
